// File: rtl/msg_sched_pkg.sv
// Shared definitions for the message request scheduler: message type codes,
// FSM state encoding and the width macros used as parameter defaults.
// Fallback values for the width macros apply only when no other definition
// has been provided earlier in the compilation unit.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 4
`endif
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 16
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 5
`endif

package msg_sched_pkg;

  // Message type codes; zero means "no message" and is never queued.
  typedef enum logic [3:0] {
    MSG_NONE       = 4'd0,
    MSG_LOGON      = 4'd1,
    MSG_LOGOUT     = 4'd2,
    MSG_HEARTBEAT  = 4'd3,
    MSG_RESEND_REQ = 4'd4
  } msg_type_e;

  // Scheduler FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_e;

  // Consecutive session grants allowed while the application is waiting.
  localparam int STARVE_LIMIT = 3;

endpackage

// File: rtl/msg_req_fifo.sv
// Session request FIFO for the message scheduler.
// Type-zero pushes are ignored; a push into a full FIFO is accepted only if
// the same cycle pops, otherwise it is dropped and the sticky overflow flag
// is set.
// Optional feature macro: MSG_SCHED_HB_COALESCE_EN -- a heartbeat push whose
// host matches a heartbeat already queued is silently discarded.
module msg_req_fifo
  import msg_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOST_W  = 4,
  parameter int VALUE_W = 16,
  parameter int SIZE_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [3:0]         push_type_i,
  input  logic [HOST_W-1:0]  push_host_i,
  input  logic [VALUE_W-1:0] push_tcid_i,
  input  logic [SIZE_W-1:0]  push_sv_i,
  input  logic               pop_i,
  output logic [3:0]         head_type_o,
  output logic [HOST_W-1:0]  head_host_o,
  output logic [VALUE_W-1:0] head_tcid_o,
  output logic [SIZE_W-1:0]  head_sv_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]         typeMem_q [DEPTH];
  logic [HOST_W-1:0]  hostMem_q [DEPTH];
  logic [VALUE_W-1:0] tcidMem_q [DEPTH];
  logic [SIZE_W-1:0]  svMem_q   [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic validPush, dupHit, doPush, doPop, dropPush;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign overflow_o = overflow_q;

  assign head_type_o = typeMem_q[rdPtr_q];
  assign head_host_o = hostMem_q[rdPtr_q];
  assign head_tcid_o = tcidMem_q[rdPtr_q];
  assign head_sv_o   = svMem_q[rdPtr_q];

  assign doPop     = pop_i && !empty_o;
  assign validPush = push_i && (push_type_i != 4'd0) && !dupHit;
  assign doPush    = validPush && (!full_o || doPop);
  assign dropPush  = validPush && full_o && !doPop;

`ifdef MSG_SCHED_HB_COALESCE_EN
  logic [PTR_W-1:0] slot;

  // Search live entries for a heartbeat to the same host; the head is skipped when it leaves this cycle.
  always_comb begin
    dupHit = 1'b0;
    slot   = rdPtr_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rdPtr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && !((i == 0) && doPop) &&
          (typeMem_q[slot] == MSG_HEARTBEAT) && (hostMem_q[slot] == push_host_i)) begin
        dupHit = 1'b1;
      end
    end
    if (push_type_i != MSG_HEARTBEAT) begin
      dupHit = 1'b0;
    end
  end
`else
  assign dupHit = 1'b0;
`endif

  // Entry storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      typeMem_q[wrPtr_q] <= push_type_i;
      hostMem_q[wrPtr_q] <= push_host_i;
      tcidMem_q[wrPtr_q] <= push_tcid_i;
      svMem_q[wrPtr_q]   <= push_sv_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (doPush && !doPop)      count_q <= count_q + CNT_W'(1);
      else if (doPop && !doPush) count_q <= count_q - CNT_W'(1);
      if (dropPush) overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/msg_request_scheduler.sv
// Message request scheduler: arbitrates between queued session-manager
// requests and a single application request, hands the winner to the
// create-message block and waits (with a timeout) for its done pulse.
// Optional feature macro: MSG_SCHED_HB_COALESCE_EN (heartbeat coalescing in
// the session FIFO).
module msg_request_scheduler
  import msg_sched_pkg::*;
#(
  parameter int NUM_HOST     = `HOST_ADDR_WIDTH,
  parameter int VALUE_WIDTH  = `VALUE_DATA_WIDTH,
  parameter int SIZE         = `VALUE_SIZE,
  parameter int DEPTH        = 4,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sess_req_i,
  input  logic [3:0]             sess_type_i,
  input  logic [NUM_HOST-1:0]    sess_host_i,
  input  logic [VALUE_WIDTH-1:0] sess_tcid_i,
  input  logic [SIZE-1:0]        sess_sv_i,
  input  logic                   app_valid_i,
  input  logic [3:0]             app_type_i,
  input  logic [NUM_HOST-1:0]    app_host_i,
  input  logic [VALUE_WIDTH-1:0] app_tcid_i,
  input  logic [SIZE-1:0]        app_sv_i,
  output logic                   app_ready_o,
  input  logic                   cm_busy_i,
  input  logic                   cm_done_i,
  output logic                   initiate_msg_o,
  output logic [3:0]             create_message_o,
  output logic [NUM_HOST-1:0]    host_o,
  output logic [VALUE_WIDTH-1:0] targetCompId_o,
  output logic [SIZE-1:0]        s_v_targetCompId_o,
  output logic                   fifo_full_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);

  localparam int WAIT_W = (DONE_TIMEOUT < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);

  sched_state_e state_q, state_d;
  logic [WAIT_W-1:0]      waitCnt_q, waitCnt_d;
  logic [1:0]             starveCnt_q, starveCnt_d;
  logic [3:0]             type_q, type_d;
  logic [NUM_HOST-1:0]    host_q, host_d;
  logic [VALUE_WIDTH-1:0] tcid_q, tcid_d;
  logic [SIZE-1:0]        sv_q, sv_d;
  logic                   timeout_q, timeout_d;

  logic [3:0]             headType;
  logic [NUM_HOST-1:0]    headHost;
  logic [VALUE_WIDTH-1:0] headTcid;
  logic [SIZE-1:0]        headSv;
  logic fifoEmpty, grant, appTurn, sessGrant, appGrant;

  msg_req_fifo #(
    .DEPTH   (DEPTH),
    .HOST_W  (NUM_HOST),
    .VALUE_W (VALUE_WIDTH),
    .SIZE_W  (SIZE)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (sess_req_i),
    .push_type_i (sess_type_i),
    .push_host_i (sess_host_i),
    .push_tcid_i (sess_tcid_i),
    .push_sv_i   (sess_sv_i),
    .pop_i       (sessGrant),
    .head_type_o (headType),
    .head_host_o (headHost),
    .head_tcid_o (headTcid),
    .head_sv_o   (headSv),
    .empty_o     (fifoEmpty),
    .full_o      (fifo_full_o),
    .overflow_o  (overflow_o)
  );

  // The session queue wins unless it is empty or has starved the waiting application.
  assign grant     = (state_q == ST_IDLE) && !cm_busy_i && (!fifoEmpty || app_valid_i);
  assign appTurn   = app_valid_i && (fifoEmpty || (starveCnt_q == 2'(STARVE_LIMIT)));
  assign sessGrant = grant && !appTurn;
  assign appGrant  = grant && appTurn;

  assign app_ready_o        = appGrant;
  assign initiate_msg_o     = (state_q == ST_ISSUE);
  assign create_message_o   = type_q;
  assign host_o             = host_q;
  assign targetCompId_o     = tcid_q;
  assign s_v_targetCompId_o = sv_q;
  assign timeout_o          = timeout_q;

  // Next-state logic: latch the winner on grant, clear the fields whenever the FSM falls back to IDLE.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    starveCnt_d = starveCnt_q;
    type_d      = type_q;
    host_d      = host_q;
    tcid_d      = tcid_q;
    sv_d        = sv_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ISSUE;
          if (sessGrant) begin
            type_d      = headType;
            host_d      = headHost;
            tcid_d      = headTcid;
            sv_d        = headSv;
            starveCnt_d = app_valid_i ? starveCnt_q + 2'd1 : 2'd0;
          end else begin
            type_d      = app_type_i;
            host_d      = app_host_i;
            tcid_d      = app_tcid_i;
            sv_d        = app_sv_i;
            starveCnt_d = 2'd0;
          end
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT_DONE;
        waitCnt_d = '0;
      end
      ST_WAIT_DONE: begin
        if (cm_done_i || (waitCnt_q == WAIT_W'(DONE_TIMEOUT))) begin
          state_d   = ST_IDLE;
          timeout_d = !cm_done_i;
          type_d    = '0;
          host_d    = '0;
          tcid_d    = '0;
          sv_d      = '0;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and held output fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      waitCnt_q   <= '0;
      starveCnt_q <= '0;
      type_q      <= '0;
      host_q      <= '0;
      tcid_q      <= '0;
      sv_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      starveCnt_q <= starveCnt_d;
      type_q      <= type_d;
      host_q      <= host_d;
      tcid_q      <= tcid_d;
      sv_q        <= sv_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule
